cla_operand_sequencer: RTL

- Upstream feeder for the N-bit carry-lookahead adder datapath/controller pair.
- Accepts a complete operand pair (A, B, carry-in) through a valid/ready handshake.
- Drives the adder's start/data_in/carry_in serial loading protocol, waits for done, then captures the N+1-bit sum into an output register with its own valid/ready handshake.
- Decouples bus-style producers from the adder's cycle-exact load sequence.

---
 rtl/cla_operand_sequencer.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/cla_operand_sequencer.sv
// cla_operand_sequencer: accepts an operand pair (A, B, cin) over valid/ready,
// plays it into the serial-load carry-lookahead adder (start pulse, A for
// A_CYCLES cycles, then B until done), and holds the N+1-bit sum in an output
// register with its own valid/ready handshake.
//
// Optional feature macro: CLA_SEQ_TIMEOUT_EN -- abort S_LOAD_B after TIMEOUT
// cycles without add_done and return out_err=1 with out_sum=0.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid/in_ready           operand handshake (in_ready is combinational)
//   in_a, in_b, in_cin          operand pair and carry-in
//   add_start                   one-cycle start pulse to the adder controller
//   add_carry_in, add_data_in   carry-in and serial operand bus to the adder
//   add_done, add_data_out      adder completion flag and N+1-bit sum
//   out_valid/out_ready         result handshake
//   out_sum                     captured sum (bit N = carry-out)
//   out_err                     result aborted by timeout
//   busy                        high whenever not idle
module cla_operand_sequencer #(
  parameter int unsigned N        = 16,
  parameter int unsigned A_CYCLES = 2,
  parameter int unsigned TIMEOUT  = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic         in_cin,
  output logic         add_start,
  output logic         add_carry_in,
  output logic [N-1:0] add_data_in,
  input  logic         add_done,
  input  logic [N:0]   add_data_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N:0]   out_sum,
  output logic         out_err,
  output logic         busy
);

  localparam int unsigned CNT_MAX = (A_CYCLES > TIMEOUT) ? A_CYCLES : TIMEOUT;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD_A, S_LOAD_B} state_t;

  state_t         state, state_d;
  logic [CW-1:0]  cnt, cnt_d;
  logic [N-1:0]   b_q, b_d;
  logic           add_start_d, add_carry_in_d;
  logic [N-1:0]   add_data_in_d;
  logic           out_valid_d, out_err_d, busy_d;
  logic [N:0]     out_sum_d;

  // Held low while reset is asserted so nothing is accepted during reset.
  assign in_ready = rst_n & (state == S_IDLE) & ~out_valid;

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      b_q          <= '0;
      add_start    <= 1'b0;
      add_carry_in <= 1'b0;
      add_data_in  <= '0;
      out_valid    <= 1'b0;
      out_sum      <= '0;
      out_err      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      b_q          <= b_d;
      add_start    <= add_start_d;
      add_carry_in <= add_carry_in_d;
      add_data_in  <= add_data_in_d;
      out_valid    <= out_valid_d;
      out_sum      <= out_sum_d;
      out_err      <= out_err_d;
      busy         <= busy_d;
    end
  end

  // Next state and next registered outputs; outputs reflect the state being entered.
  always_comb begin
    state_d        = state;
    cnt_d          = cnt;
    b_d            = b_q;
    add_start_d    = 1'b0;
    add_carry_in_d = add_carry_in;
    add_data_in_d  = add_data_in;
    out_valid_d    = out_valid;
    out_sum_d      = out_sum;
    out_err_d      = out_err;
    busy_d         = busy;

    if (out_valid && out_ready) begin
      out_valid_d = 1'b0;
      out_err_d   = 1'b0;
    end

    unique case (state)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          state_d        = S_LOAD_A;
          cnt_d          = '0;
          b_d            = in_b;
          add_start_d    = 1'b1;
          add_carry_in_d = in_cin;
          add_data_in_d  = in_a;
          busy_d         = 1'b1;
        end
      end

      // add_done is deliberately ignored while A is on the bus.
      S_LOAD_A: begin
        cnt_d = cnt + CW'(1);
        if (cnt == CW'(A_CYCLES - 1)) begin
          state_d       = S_LOAD_B;
          cnt_d         = '0;
          add_data_in_d = b_q;
        end
      end

      S_LOAD_B: begin
`ifdef CLA_SEQ_TIMEOUT_EN
        cnt_d = cnt + CW'(1);
`endif
        if (add_done) begin
          state_d        = S_IDLE;
          cnt_d          = '0;
          out_valid_d    = 1'b1;
          out_sum_d      = add_data_out;
          out_err_d      = 1'b0;
          busy_d         = 1'b0;
          add_data_in_d  = '0;
          add_carry_in_d = 1'b0;
        end
`ifdef CLA_SEQ_TIMEOUT_EN
        // A done on the final allowed cycle takes priority over the abort.
        else if (cnt == CW'(TIMEOUT - 1)) begin
          state_d        = S_IDLE;
          cnt_d          = '0;
          out_valid_d    = 1'b1;
          out_sum_d      = '0;
          out_err_d      = 1'b1;
          busy_d         = 1'b0;
          add_data_in_d  = '0;
          add_carry_in_d = 1'b0;
        end
`endif
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule
